// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one byte-wide UART transmit serializer between two
// message sources. A requester owns the serializer for a whole message
// (through its last byte); contention is settled round-robin, and a stall
// watchdog revokes ownership from an owner that stops offering bytes.
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   req0_valid/data/last    requester 0 byte stream
//   req0_ready              requester 0 byte accepted this cycle
//   req1_valid/data/last    requester 1 byte stream
//   req1_ready              requester 1 byte accepted this cycle
//   tx_valid/tx_data        byte offered to the serializer (owner pass-through)
//   tx_ready                serializer can start a frame
//   grant                   one-hot current owner, 2'b00 when none
//   busy                    a grant is held
//   abort                   one-cycle pulse on a watchdog release
module uart_tx_arbiter #(
    parameter int unsigned      CNT_W   = 20,
    parameter logic [CNT_W-1:0] TIMEOUT = 20'd104210
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic [1:0] grant,
    output logic       busy,
    output logic       abort
);

    // Stall count at which the owner is released (TIMEOUT stalled cycles).
    localparam logic [CNT_W-1:0] EXPIRE  = TIMEOUT - CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // State encoding doubles as the one-hot owner id.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] stall_cnt_nxt;
    // One-hot id of the last requester served; 2'b00 means no history,
    // in which case requester 0 wins a tie.
    logic [1:0]       rr_last;
    logic [1:0]       rr_last_nxt;
    logic             abort_nxt;
    logic             owner_last;

    // State register plus registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            stall_cnt <= '0;
            rr_last   <= 2'b00;
            grant     <= 2'b00;
            busy      <= 1'b0;
            abort     <= 1'b0;
        end else begin
            state     <= state_nxt;
            stall_cnt <= stall_cnt_nxt;
            rr_last   <= rr_last_nxt;
            grant     <= 2'(state_nxt);
            busy      <= (state_nxt != IDLE);
            abort     <= abort_nxt;
        end
    end

    // Next-state, round-robin pointer and stall watchdog.
    always_comb begin
        state_nxt     = state;
        stall_cnt_nxt = stall_cnt;
        rr_last_nxt   = rr_last;
        abort_nxt     = 1'b0;
        unique case (state)
            IDLE: begin
                stall_cnt_nxt = '0;
                if (req0_valid && req1_valid) begin
                    state_nxt = (rr_last == 2'b01) ? OWN1 : OWN0;
                end else if (req0_valid) begin
                    state_nxt = OWN0;
                end else if (req1_valid) begin
                    state_nxt = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (tx_valid) begin
                    // Owner is offering a byte: not a stall, even if the
                    // serializer is still busy.
                    stall_cnt_nxt = '0;
                    if (tx_ready && owner_last) begin
                        state_nxt   = IDLE;
                        rr_last_nxt = 2'(state);
                    end
                end else if (stall_cnt >= EXPIRE) begin
                    state_nxt     = IDLE;
                    rr_last_nxt   = 2'(state);
                    abort_nxt     = 1'b1;
                    stall_cnt_nxt = '0;
                end else if (stall_cnt != CNT_MAX) begin
                    stall_cnt_nxt = stall_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt     = IDLE;
                stall_cnt_nxt = '0;
            end
        endcase
    end

    // Owner pass-through to the serializer.
    always_comb begin
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        owner_last = 1'b0;
        unique case (state)
            OWN0: begin
                tx_valid   = req0_valid;
                tx_data    = req0_data;
                req0_ready = tx_ready;
                owner_last = req0_last;
            end
            OWN1: begin
                tx_valid   = req1_valid;
                tx_data    = req1_data;
                req1_ready = tx_ready;
                owner_last = req1_last;
            end
            default: begin
                tx_valid   = 1'b0;
                tx_data    = 8'h00;
                req0_ready = 1'b0;
                req1_ready = 1'b0;
                owner_last = 1'b0;
            end
        endcase
    end

endmodule
